// File: rtl/aad_pool_stream_if.sv
// Handshake bundle for aad_pool_stream: pixel input stream and tile-result output stream.
// The engine binds the slave modport; the pixel source / result consumer binds master.
interface aad_pool_stream_if #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int TILE  = 2
);
  localparam int SUM_W = PIX_W + $clog2(TILE * (TILE - 1));
  localparam int TR_W  = (IMG_H / TILE > 1) ? $clog2(IMG_H / TILE) : 1;
  localparam int TC_W  = (IMG_W / TILE > 1) ? $clog2(IMG_W / TILE) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic [TR_W-1:0]  out_trow;
  logic [TC_W-1:0]  out_tcol;
  logic [SUM_W-1:0] out_hsum;
  logic [SUM_W-1:0] out_vsum;
  logic [SUM_W-1:0] out_havg;
  logic [SUM_W-1:0] out_vavg;
  logic             frame_done;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_trow, out_tcol,
    input  out_hsum, out_vsum, out_havg, out_vavg, frame_done
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_trow, out_tcol,
    output out_hsum, out_vsum, out_havg, out_vavg, frame_done
  );
endinterface

// File: rtl/aad_pool_stream.sv
// Streaming AAD pooling engine: per-tile sums of absolute horizontal/vertical neighbour
// differences plus sum/DIV, delivered through a show-ahead FIFO. Define AAD_ROUND_EN to round the averages.
module aad_pool_stream #(
  parameter int PIX_W     = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int TILE      = 2,
  parameter int DIV       = 12,
  parameter int OUT_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  aad_pool_stream_if.slave bus
);
  localparam int SUM_W = PIX_W + $clog2(TILE * (TILE - 1));
  localparam int NTC   = IMG_W / TILE;
  localparam int NTR   = IMG_H / TILE;
  localparam int TC_W  = (NTC > 1) ? $clog2(NTC) : 1;
  localparam int TR_W  = (NTR > 1) ? $clog2(NTR) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW    = $clog2(TILE);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic [SW-1:0]    T_LAST  = SW'(TILE - 1);
  localparam logic [CW-1:0]    C_LAST  = CW'(IMG_W - 1);
  localparam logic [TC_W-1:0]  TC_LAST = TC_W'(NTC - 1);
  localparam logic [TR_W-1:0]  TR_LAST = TR_W'(NTR - 1);
  localparam logic [PTR_W-1:0] P_LAST  = PTR_W'(OUT_DEPTH - 1);

  typedef struct packed {
    logic [TR_W-1:0]  trow;
    logic [TC_W-1:0]  tcol;
    logic [SUM_W-1:0] hsum;
    logic [SUM_W-1:0] vsum;
    logic [SUM_W-1:0] havg;
    logic [SUM_W-1:0] vavg;
  } ent_t;

  function automatic logic [PIX_W-1:0] f_absdiff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Single-stage constant division; the rounding bias needs one extra bit of headroom.
  function automatic logic [SUM_W-1:0] f_avg(input logic [SUM_W-1:0] x);
    logic [SUM_W:0] w;
    logic [31:0]    q;
`ifdef AAD_ROUND_EN
    w = {1'b0, x} + (SUM_W + 1)'(DIV / 2);
`else
    w = {1'b0, x};
`endif
    q = 32'(w) / 32'(DIV);
    return (q > 32'((2 ** SUM_W) - 1)) ? '1 : q[SUM_W-1:0];
  endfunction

  logic [CW-1:0]    r_col;
  logic [SW-1:0]    r_cin, r_rin;
  logic [TC_W-1:0]  r_tc;
  logic [TR_W-1:0]  r_tr;
  logic             r_live;
  logic [PIX_W-1:0] r_prev;
  logic [PIX_W-1:0] r_lb [IMG_W];
  logic [SUM_W-1:0] r_acc_h [NTC];
  logic [SUM_W-1:0] r_acc_v [NTC];

  logic             r_vld_p0, r_vld_p1;
  logic [TR_W-1:0]  r_trow_p0, r_trow_p1;
  logic [TC_W-1:0]  r_tcol_p0, r_tcol_p1;
  logic [SUM_W-1:0] r_hsum_p1, r_vsum_p1;

  ent_t             r_mem [OUT_DEPTH];
  ent_t             r_hold;
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;

  logic             w_xfer, w_first, w_last, w_push, w_pop;
  logic [PIX_W-1:0] w_hd, w_vd;
  logic [CNT_W:0]   w_used;
  ent_t             w_head, w_new;

  assign w_xfer  = bus.in_valid & bus.in_ready;
  assign w_first = (r_rin == '0) && (r_cin == '0);
  assign w_last  = (r_rin == T_LAST) && (r_cin == T_LAST);
  assign w_hd    = (r_cin != '0) ? f_absdiff(bus.in_pix, r_prev) : '0;
  assign w_vd    = (r_rin != '0) ? f_absdiff(bus.in_pix, r_lb[r_col]) : '0;

  // Raster position kept as intra-tile offsets plus tile indices to avoid runtime division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_cin  <= '0;
      r_tc   <= '0;
      r_rin  <= '0;
      r_tr   <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_xfer) begin
        r_col <= (r_col == C_LAST) ? '0 : r_col + CW'(1);
        if (r_cin != T_LAST) begin
          r_cin <= r_cin + SW'(1);
        end else begin
          r_cin <= '0;
          if (r_tc != TC_LAST) begin
            r_tc <= r_tc + TC_W'(1);
          end else begin
            r_tc <= '0;
            if (r_rin != T_LAST) begin
              r_rin <= r_rin + SW'(1);
            end else begin
              r_rin <= '0;
              r_tr  <= (r_tr == TR_LAST) ? '0 : r_tr + TR_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_prev       <= bus.in_pix;
      r_lb[r_col]  <= bus.in_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTC; i++) begin
        r_acc_h[i] <= '0;
        r_acc_v[i] <= '0;
      end
    end else if (w_xfer) begin
      if (w_first) begin
        r_acc_h[r_tc] <= '0;
        r_acc_v[r_tc] <= '0;
      end else begin
        r_acc_h[r_tc] <= r_acc_h[r_tc] + SUM_W'(w_hd);
        r_acc_v[r_tc] <= r_acc_v[r_tc] + SUM_W'(w_vd);
      end
    end
  end

  // Stage p0: tile-complete flag and indices; p1: final sums read from the accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p0 <= w_xfer & w_last;
      r_vld_p1 <= r_vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && w_last) begin
      r_trow_p0 <= r_tr;
      r_tcol_p0 <= r_tc;
    end
    if (r_vld_p0) begin
      r_trow_p1 <= r_trow_p0;
      r_tcol_p1 <= r_tcol_p0;
      r_hsum_p1 <= r_acc_h[r_tcol_p0];
      r_vsum_p1 <= r_acc_v[r_tcol_p0];
    end
  end

  // Stage p2: quotients formed on the way into the FIFO.
  assign w_push = r_vld_p1;
  assign w_pop  = (r_cnt != '0) & bus.out_ready;
  assign w_head = (r_cnt != '0) ? r_mem[r_rp] : r_hold;

  always_comb begin
    w_new      = '0;
    w_new.trow = r_trow_p1;
    w_new.tcol = r_tcol_p1;
    w_new.hsum = r_hsum_p1;
    w_new.vsum = r_vsum_p1;
    w_new.havg = f_avg(r_hsum_p1);
    w_new.vavg = f_avg(r_vsum_p1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == P_LAST) ? '0 : r_wp + PTR_W'(1);
      if (w_pop) begin
        r_rp   <= (r_rp == P_LAST) ? '0 : r_rp + PTR_W'(1);
        r_hold <= r_mem[r_rp];
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Tiles still in p0/p1 already own a FIFO slot, so they count against the free space.
  assign w_used = (CNT_W + 1)'(r_cnt) + (CNT_W + 1)'(r_vld_p0) + (CNT_W + 1)'(r_vld_p1);

  assign bus.in_ready   = r_live && (w_used < (CNT_W + 1)'(OUT_DEPTH));
  assign bus.out_valid  = (r_cnt != '0);
  assign bus.out_trow   = w_head.trow;
  assign bus.out_tcol   = w_head.tcol;
  assign bus.out_hsum   = w_head.hsum;
  assign bus.out_vsum   = w_head.vsum;
  assign bus.out_havg   = w_head.havg;
  assign bus.out_vavg   = w_head.vavg;
  assign bus.frame_done = w_pop && (w_head.trow == TR_LAST) && (w_head.tcol == TC_LAST);
endmodule
